sram_responder: RTL

//  Memory-side responder for the LC-3 SRAM bus driven by the control unit.

---
 rtl/sram_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// LC-3 SRAM bus responder: word array with programmable read/write latency,
// active-low byte-lane selects and a sticky protocol error flag.
module sram_responder #(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 1,
  parameter int WRITE_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic              Mem_UB,
  input  logic              Mem_LB,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [15:0]       Data_to_SRAM,
  output logic [15:0]       Data_from_SRAM,
  output logic              Data_valid,
  output logic              Busy,
  output logic              Protocol_err,
  input  logic              Init_en,
  input  logic [ADDR_W-1:0] Init_addr,
  input  logic [15:0]       Init_data
);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    HOLD
  } state_e;

  localparam logic [2:0] RD_CNT = 3'(READ_LAT - 1);
  localparam logic [2:0] WR_CNT = 3'(WRITE_LAT - 1);

  logic [15:0]       mem [0:(2**ADDR_W)-1];

  state_e            state_q;
  logic [2:0]        count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              ub_q;
  logic              lb_q;
  logic [15:0]       dout_q;
  logic              valid_q;
  logic              err_q;

  logic              rd_req_d;
  logic              wr_req_d;
  logic              clash_d;
  logic              hold_d;

  function automatic logic [15:0] lanes(
    input logic [15:0] w,
    input logic        ub,
    input logic        lb
  );
    return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
  endfunction

  always_comb begin
    clash_d  = !Mem_CE && !Mem_OE && !Mem_WE;
    rd_req_d = !Mem_CE && !Mem_OE && Mem_WE;
    wr_req_d = !Mem_CE && !Mem_WE && Mem_OE;
    hold_d   = !Mem_CE && (!Mem_OE || !Mem_WE);
  end

  // The array sits in the reset block so a write pending at reset never lands.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      dout_q  <= 16'h0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Init_en) begin
            mem[Init_addr] <= Init_data;
          end else if (clash_d) begin
            err_q <= 1'b1;
          end else if (rd_req_d) begin
            addr_q <= ADDR;
            ub_q   <= Mem_UB;
            lb_q   <= Mem_LB;
            if (READ_LAT == 1) begin
              dout_q  <= lanes(mem[ADDR], Mem_UB, Mem_LB);
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              count_q <= RD_CNT;
              state_q <= RD_WAIT;
            end
          end else if (wr_req_d) begin
            addr_q  <= ADDR;
            wdata_q <= Data_to_SRAM;
            ub_q    <= Mem_UB;
            lb_q    <= Mem_LB;
            if (WRITE_LAT == 1) begin
              if (!Mem_UB) mem[ADDR][15:8] <= Data_to_SRAM[15:8];
              if (!Mem_LB) mem[ADDR][7:0]  <= Data_to_SRAM[7:0];
              state_q <= HOLD;
            end else begin
              count_q <= WR_CNT;
              state_q <= WR_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (Mem_CE || Mem_OE) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (count_q == 3'd1) begin
            dout_q  <= lanes(mem[addr_q], ub_q, lb_q);
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            count_q <= count_q - 3'd1;
          end
        end
        WR_WAIT: begin
          if (Mem_CE || Mem_WE) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else if (count_q == 3'd1) begin
            if (!ub_q) mem[addr_q][15:8] <= wdata_q[15:8];
            if (!lb_q) mem[addr_q][7:0]  <= wdata_q[7:0];
            state_q <= HOLD;
          end else begin
            count_q <= count_q - 3'd1;
          end
        end
        HOLD: begin
          if (!hold_d) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Data_from_SRAM = dout_q;
  assign Data_valid     = valid_q;
  assign Busy           = (state_q != IDLE);
  assign Protocol_err   = err_q;

endmodule
